// File: rtl/stack_ctrl_if.sv
// Command/status bundle between the control unit (master) and the hardware stack (slave).
interface stack_ctrl_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CW    = 11
);
    logic             clear;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    modport master (
        output clear, push, pop, din,
        input  dout, count, empty, full, overflow, underflow
    );

    modport slave (
        input  clear, push, pop, din,
        output dout, count, empty, full, overflow, underflow
    );
endinterface

// File: rtl/stack_ctrl.sv
// Hardware LIFO stack: owns its stack pointer, tracks occupancy and sticky error flags,
// supports replace-top (push+pop) and synchronous flush.
module stack_ctrl #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 1024
) (
    input  logic        clk,
    input  logic        reset,
    stack_ctrl_if.slave bus
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;

    logic [CW-1:0]    top_cnt;
    logic [AW-1:0]    top_addr;
    logic             is_empty;
    logic             is_full;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CW'(DEPTH));
    assign top_cnt  = count_q - CW'(1);
    assign top_addr = AW'(top_cnt);

    // Command decode: clear wins, illegal commands only raise a sticky flag.
    always_comb begin
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = bus.din;
        if (bus.clear) begin
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else if (bus.push && !bus.pop) begin
            if (!is_full) begin
                wr_en   = 1'b1;
                wr_addr = AW'(count_q);
                count_d = count_q + CW'(1);
            end else begin
                overflow_d = 1'b1;
            end
        end else if (bus.pop && !bus.push) begin
            if (!is_empty) begin
                count_d = top_cnt;
            end else begin
                underflow_d = 1'b1;
            end
        end else if (bus.pop && bus.push) begin
            // Replace-top keeps the count, so it is legal even when full.
            if (!is_empty) begin
                wr_en   = 1'b1;
                wr_addr = top_addr;
            end else begin
                underflow_d = 1'b1;
            end
        end
    end

    // Pointer and error flags, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; contents beyond count are don't-care so it carries no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign bus.dout      = is_empty ? '0 : mem_q[top_addr];
    assign bus.count     = count_q;
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_stack_ctrl.sv
// Directed and model-checked bench for stack_ctrl with a 4-entry stack.
module tb_stack_ctrl;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic reset;

    int n_checks = 0;
    int n_fail   = 0;

    stack_ctrl_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

    stack_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Single comparison point for every check in the bench.
    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Apply one command across a rising edge, then leave the bus idle.
    task automatic cmd(input logic c, input logic p, input logic q, input logic [WIDTH-1:0] d);
        bus.clear = c;
        bus.push  = p;
        bus.pop   = q;
        bus.din   = d;
        @(posedge clk);
        #1;
        bus.clear = 1'b0;
        bus.push  = 1'b0;
        bus.pop   = 1'b0;
    endtask

    task automatic check_state(input string tag, input int cnt, input logic [WIDTH-1:0] top,
                               input logic ovf, input logic udf);
        check_val({tag, ".count"}, 32'(bus.count), 32'(cnt));
        check_val({tag, ".dout"},  32'(bus.dout),  32'(top));
        check_val({tag, ".empty"}, 32'(bus.empty), 32'(cnt == 0));
        check_val({tag, ".full"},  32'(bus.full),  32'(cnt == DEPTH));
        check_val({tag, ".ovf"},   32'(bus.overflow),  32'(ovf));
        check_val({tag, ".udf"},   32'(bus.underflow), 32'(udf));
    endtask

    logic [WIDTH-1:0] m [DEPTH];
    int               mcnt;
    logic             movf, mudf;

    initial begin
        reset     = 1'b1;
        bus.clear = 1'b0;
        bus.push  = 1'b0;
        bus.pop   = 1'b0;
        bus.din   = '0;
        repeat (2) @(posedge clk);
        #1;
        check_state("reset", 0, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Basic push/pop ordering.
        cmd(0, 1, 0, 16'h1111);
        cmd(0, 1, 0, 16'h2222);
        cmd(0, 1, 0, 16'h3333);
        check_state("t1.push3", 3, 16'h3333, 0, 0);
        cmd(0, 0, 1, '0);
        check_state("t1.pop1", 2, 16'h2222, 0, 0);
        cmd(0, 0, 1, '0);
        check_state("t1.pop2", 1, 16'h1111, 0, 0);
        cmd(0, 0, 1, '0);
        check_state("t1.pop3", 0, 16'h0000, 0, 0);

        // Fill to full, overflow, then drain.
        for (int i = 0; i < 4; i++) cmd(0, 1, 0, 16'(16'hA0 + i));
        check_state("t2.full", 4, 16'h00A3, 0, 0);
        cmd(0, 1, 0, 16'h00A4);
        check_state("t2.ovf", 4, 16'h00A3, 1, 0);
        cmd(0, 0, 1, '0);
        check_state("t2.pop1", 3, 16'h00A2, 1, 0);
        cmd(0, 0, 1, '0);
        check_state("t2.pop2", 2, 16'h00A1, 1, 0);
        cmd(0, 0, 1, '0);
        check_state("t2.pop3", 1, 16'h00A0, 1, 0);
        cmd(0, 0, 1, '0);
        check_state("t2.pop4", 0, 16'h0000, 1, 0);
        cmd(1, 0, 0, '0);
        check_state("t2.clr", 0, 16'h0000, 0, 0);

        // Underflow is sticky until clear.
        cmd(0, 0, 1, '0);
        check_state("t3.udf", 0, 16'h0000, 0, 1);
        cmd(0, 1, 0, 16'h0055);
        check_state("t3.push", 1, 16'h0055, 0, 1);
        cmd(1, 0, 0, '0);
        check_state("t3.clr", 0, 16'h0000, 0, 0);

        // Replace-top, including at full and on empty.
        cmd(0, 1, 0, 16'h00AA);
        cmd(0, 1, 1, 16'h00BB);
        check_state("t4.repl", 1, 16'h00BB, 0, 0);
        cmd(0, 1, 0, 16'h0001);
        cmd(0, 1, 0, 16'h0002);
        cmd(0, 1, 0, 16'h0003);
        cmd(0, 1, 1, 16'h00CC);
        check_state("t4.replfull", 4, 16'h00CC, 0, 0);
        cmd(0, 0, 1, '0);
        check_state("t4.below", 3, 16'h0002, 0, 0);
        cmd(1, 0, 0, '0);
        cmd(0, 1, 1, 16'h00DD);
        check_state("t4.replempty", 0, 16'h0000, 0, 1);
        cmd(1, 0, 0, '0);

        // Clear has priority over push.
        cmd(0, 1, 0, 16'h0011);
        cmd(0, 1, 0, 16'h0022);
        cmd(1, 1, 0, 16'h0099);
        check_state("t5.clrpush", 0, 16'h0000, 0, 0);
        cmd(0, 1, 0, 16'h0077);
        check_state("t5.after", 1, 16'h0077, 0, 0);
        cmd(1, 0, 0, '0);

        // Asynchronous reset between edges with flags set.
        for (int i = 0; i < 4; i++) cmd(0, 1, 0, 16'(16'h10 + i));
        cmd(0, 1, 0, 16'h0014);
        cmd(0, 0, 1, '0);
        check_state("t6.pre", 3, 16'h0012, 1, 0);
        #3;
        reset = 1'b1;
        #1;
        check_state("t6.async", 0, 16'h0000, 0, 0);
        @(posedge clk);
        #1;
        check_state("t6.held", 0, 16'h0000, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        cmd(0, 1, 0, 16'h0042);
        check_state("t6.first", 1, 16'h0042, 0, 0);

        // Random command run against a reference model.
        cmd(1, 0, 0, '0);
        mcnt = 0;
        movf = 1'b0;
        mudf = 1'b0;
        for (int n = 0; n < 300; n++) begin
            int unsigned r;
            logic c, p, q;
            logic [WIDTH-1:0] d;
            r = $urandom_range(0, 31);
            c = (r == 0);
            p = r[1];
            q = r[2];
            d = 16'($urandom);
            if (c) begin
                mcnt = 0;
                movf = 1'b0;
                mudf = 1'b0;
            end else if (p && !q) begin
                if (mcnt < DEPTH) begin
                    m[mcnt] = d;
                    mcnt++;
                end else movf = 1'b1;
            end else if (q && !p) begin
                if (mcnt > 0) mcnt--;
                else mudf = 1'b1;
            end else if (p && q) begin
                if (mcnt > 0) m[mcnt-1] = d;
                else mudf = 1'b1;
            end
            cmd(c, p, q, d);
            check_state("rand", mcnt, (mcnt == 0) ? 16'h0000 : m[mcnt-1], movf, mudf);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
